// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared instruction-memory geometry and loader state encoding
package rv_mem_pkg;

  // Byte-organised instruction memory: 512 cells, 9-bit byte address
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 512;

  // Boot loader sequencing
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream writer for the instruction memory
module imem_loader
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum,
  output logic              core_hold
);

  // Counter and length need one extra bit so that a full DEPTH image is representable
  localparam int LEN_W = ADDR_W + 1;

  ldr_state_e        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              core_hold_q, core_hold_d;

  logic              len_ok;
  logic              hs;

  // s_ready is the only combinational output: open while bytes remain in LOAD
  assign s_ready = (state_q == LOAD) && (cnt_q < len_q);
  assign hs      = s_valid && s_ready;
  assign len_ok  = (length != '0) && (length <= LEN_W'(DEPTH));

  // Next-state and next-output decode for the load sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    checksum_d  = checksum_q;
    core_hold_d = core_hold_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len_ok) begin
            state_d     = LOAD;
            len_d       = length;
            cnt_d       = '0;
            checksum_d  = 8'h00;
            err_d       = 1'b0;
            core_hold_d = 1'b1;
            done_d      = 1'b0;
            busy_d      = 1'b1;
          end else begin
            // Rejected start: the core stays in whatever hold state it was in
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end

      LOAD: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = s_data;
          cnt_d       = cnt_q + LEN_W'(1);
          checksum_d  = checksum_q + s_data;
          if (cnt_q + LEN_W'(1) == len_q) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // Final strobe is on the bus this cycle; release the core next cycle
        state_d     = DONE;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        core_hold_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial image
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= 8'h00;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      checksum_q  <= checksum_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;
  assign core_hold = core_hold_q;

endmodule
